// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array: default widths, range
// bounds per width and the saturating adder also used by the adder tree.
package systolic_pkg;

   localparam int DEF_DW = 16;
   localparam int DEF_AW = 40;
   localparam int DEF_OW = 16;
   localparam int MAX_AW = 64;

   // 64-bit carrier for a saturating sum; the value is sign/zero-extended
   // from the working width it was clamped to.
   typedef struct packed {
      logic [63:0] sum;
      logic        sat;
   } sat_res_t;

   // Largest two's-complement value of width w, as a 64-bit pattern.
   function automatic logic [63:0] smax(input int unsigned w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   // Smallest two's-complement value of width w, sign-extended to 64 bits.
   function automatic logic [63:0] smin(input int unsigned w);
      return ~smax(w);
   endfunction

   // Largest unsigned value of width w.
   function automatic logic [63:0] umax(input int unsigned w);
      return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

   localparam logic [63:0] OUT_SMAX = smax(DEF_OW);
   localparam logic [63:0] OUT_SMIN = smin(DEF_OW);
   localparam logic [63:0] OUT_UMAX = umax(DEF_OW);
   localparam logic [63:0] ACC_SMAX = smax(DEF_AW);
   localparam logic [63:0] ACC_SMIN = smin(DEF_AW);
   localparam logic [63:0] ACC_UMAX = umax(DEF_AW);
   localparam logic [63:0] UMIN     = 64'd0;

   // x + y clamped to the range of a w-bit signed (sgn=1) or unsigned
   // (sgn=0) number. Operands must already be extended from width w to
   // 64 bits; two guard bits keep the raw sum exact for w up to 64.
   function automatic sat_res_t sat_add(input logic [63:0] x,
                                        input logic [63:0] y,
                                        input int unsigned w,
                                        input logic        sgn);
      logic signed [65:0] xe, ye, s, hi, lo;
      sat_res_t           r;
      xe = sgn ? $signed({{2{x[63]}}, x}) : $signed({2'b00, x});
      ye = sgn ? $signed({{2{y[63]}}, y}) : $signed({2'b00, y});
      s  = xe + ye;
      hi = sgn ? $signed({2'b00, smax(w)}) : $signed({2'b00, umax(w)});
      lo = sgn ? $signed({2'b11, smin(w)}) : 66'sd0;
      if (s > hi) begin
         r.sum = hi[63:0];
         r.sat = 1'b1;
      end else if (s < lo) begin
         r.sum = lo[63:0];
         r.sat = 1'b1;
      end else begin
         r.sum = s[63:0];
         r.sat = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/dsp_round_sat.sv
// Output finaliser: rounds the accumulator half-up, shifts out SHIFT
// fractional bits and clamps to the OW-bit output range.
module dsp_round_sat
   import systolic_pkg::*;
#(
   parameter int AW     = DEF_AW,
   parameter int OW     = DEF_OW,
   parameter int SHIFT  = 0,
   parameter int SIGNED = 1
) (
   input  logic [AW-1:0] acc_in,
   output logic [OW-1:0] s_out,
   output logic          narrow_sat
);

   localparam bit          SGN  = (SIGNED != 0);
   // Half an output LSB; zero when SHIFT=0 so the rounding add is a no-op.
   localparam logic [63:0] RND  = (64'd1 << SHIFT) >> 1;
   localparam logic [63:0] OMAX = SGN ? smax(OW) : umax(OW);
   localparam logic [63:0] OMIN = SGN ? smin(OW) : 64'd0;

   typedef struct packed {
      logic [OW-1:0] val;
      logic          hit;
   } out_res_t;

   function automatic logic [63:0] widen(input logic [AW-1:0] v);
      return SGN ? 64'($signed(v)) : 64'(v);
   endfunction

   function automatic sat_res_t round_half_up(input logic [63:0] v);
      return sat_add(v, RND, AW, SGN);
   endfunction

   function automatic logic [63:0] rshift(input logic [63:0] v);
      return SGN ? 64'($signed(v) >>> SHIFT) : (v >> SHIFT);
   endfunction

   function automatic out_res_t clamp_out(input logic [63:0] v);
      out_res_t r;
      r.hit = 1'b1;
      if (SGN ? ($signed(v) > $signed(OMAX)) : (v > OMAX)) begin
         r.val = OMAX[OW-1:0];
      end else if (SGN && ($signed(v) < $signed(OMIN))) begin
         r.val = OMIN[OW-1:0];
      end else begin
         r.val = v[OW-1:0];
         r.hit = 1'b0;
      end
      return r;
   endfunction

   sat_res_t    rnd;
   logic [63:0] shifted;
   out_res_t    fin;

   // Round, shift and narrow; any clamp along the way flags narrow_sat.
   always_comb begin
      rnd     = round_half_up(widen(acc_in));
      shifted = rshift(rnd.sum);
      fin     = clamp_out(shifted);
   end

   assign s_out      = fin.val;
   assign narrow_sat = rnd.sat | fin.hit;

endmodule

// File: rtl/dsp_mac_acc.sv
// Pipelined multiply-accumulate PE for the systolic array. Three register
// stages (operands, product, accumulator/output); groups are closed by
// in_last and the accumulator re-seeds on the same edge so dot-products
// stream back to back at one product per clock.
module dsp_mac_acc
   import systolic_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int AW     = DEF_AW,
   parameter int OW     = DEF_OW,
   parameter int SHIFT  = 0,
   parameter int SIGNED = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          in_vld,
   input  logic          in_last,
   input  logic [DW-1:0] a_value,
   input  logic [DW-1:0] b_value,
   output logic          out_vld,
   output logic [OW-1:0] s_out,
   output logic          sat,
   output logic          busy
);

   localparam int PW  = 2 * DW;
   localparam bit SGN = (SIGNED != 0);

   typedef struct packed {
      logic [AW-1:0] val;
      logic          hit;
   } acc_res_t;

   logic          vld_p1, last_p1;
   logic [DW-1:0] a_p1, b_p1;
   logic          vld_p2, last_p2;
   logic [PW-1:0] prod_p2;
   logic [AW-1:0] acc;
   logic          acc_sat;
   logic          grp_open;
   acc_res_t      acc_res;
   logic [OW-1:0] fin_val;
   logic          narrow_sat;

   // Full-width product; operands are extended before multiplying so the
   // result is exact for both signed and unsigned operation.
   function automatic logic [PW-1:0] mul(input logic [DW-1:0] x,
                                         input logic [DW-1:0] y);
      logic signed [PW-1:0] ps;
      logic        [PW-1:0] pu;
      ps = PW'($signed(x)) * PW'($signed(y));
      pu = PW'(x) * PW'(y);
      return SGN ? ps : pu;
   endfunction

   // Saturating accumulate of one product into the AW-bit accumulator.
   function automatic acc_res_t acc_add(input logic [AW-1:0] a,
                                        input logic [PW-1:0] p);
      sat_res_t r;
      acc_res_t o;
      r = sat_add(SGN ? 64'($signed(a)) : 64'(a),
                  SGN ? 64'($signed(p)) : 64'(p), AW, SGN);
      o.val = r.sum[AW-1:0];
      o.hit = r.sat;
      return o;
   endfunction

   assign acc_res = acc_add(acc, prod_p2);

   dsp_round_sat #(
      .AW     (AW),
      .OW     (OW),
      .SHIFT  (SHIFT),
      .SIGNED (SIGNED)
   ) u_round_sat (
      .acc_in     (acc_res.val),
      .s_out      (fin_val),
      .narrow_sat (narrow_sat)
   );

   // S1: capture operands and group tag for each valid input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         a_p1    <= '0;
         b_p1    <= '0;
      end else if (clr) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_vld;
         if (in_vld) begin
            last_p1 <= in_last;
            a_p1    <= a_value;
            b_p1    <= b_value;
         end
      end
   end

   // S2: register the full-width product alongside its valid and tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2  <= 1'b0;
         last_p2 <= 1'b0;
         prod_p2 <= '0;
      end else if (clr) begin
         vld_p2  <= 1'b0;
         last_p2 <= 1'b0;
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            last_p2 <= last_p1;
            prod_p2 <= mul(a_p1, b_p1);
         end
      end
   end

   // S3: accumulate; a closing product re-seeds the accumulator to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         acc_sat  <= 1'b0;
         grp_open <= 1'b0;
      end else if (clr) begin
         acc      <= '0;
         acc_sat  <= 1'b0;
         grp_open <= 1'b0;
      end else if (vld_p2) begin
         if (last_p2) begin
            acc      <= '0;
            acc_sat  <= 1'b0;
            grp_open <= 1'b0;
         end else begin
            acc      <= acc_res.val;
            acc_sat  <= acc_sat | acc_res.hit;
            grp_open <= 1'b1;
         end
      end
   end

   // S3: publish the finalised group result; s_out/sat hold between groups.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld <= 1'b0;
         s_out   <= '0;
         sat     <= 1'b0;
      end else if (clr) begin
         out_vld <= 1'b0;
      end else begin
         out_vld <= vld_p2 & last_p2;
         if (vld_p2 && last_p2) begin
            s_out <= fin_val;
            sat   <= acc_sat | acc_res.hit | narrow_sat;
         end
      end
   end

   assign busy = vld_p1 | vld_p2 | grp_open;

endmodule

// File: tb/tb_dsp_mac_acc.sv
// Bench for dsp_mac_acc: four parameterisations share one stimulus stream
// and are checked against a wide-integer reference model via a scoreboard.
module tb_dsp_mac_acc;

   logic        clk = 1'b0;
   logic        rst_n, clr, in_vld, in_last;
   logic [15:0] a_value, b_value;
   logic [3:0]  ovld, osat, obusy;
   logic [3:0][15:0] sout;

   typedef struct packed {
      logic [31:0]      due;
      logic [3:0][15:0] s;
      logic [3:0]       sat;
   } exp_t;

   exp_t             sb[$];
   int               n_cmp = 0;
   int               n_err = 0;
   int               cyc   = 0;
   logic signed [127:0] macc [4];
   logic             mst [4];
   logic [15:0]      last_s [4];
   logic             last_sat [4];

   always #5 clk = ~clk;

   // u0: AW=40 SHIFT=0 signed; u1: AW=32; u2: SHIFT=8; u3: unsigned
   dsp_mac_acc #(.DW(16), .AW(40), .OW(16), .SHIFT(0), .SIGNED(1)) u0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_last(in_last),
      .a_value(a_value), .b_value(b_value),
      .out_vld(ovld[0]), .s_out(sout[0]), .sat(osat[0]), .busy(obusy[0]));
   dsp_mac_acc #(.DW(16), .AW(32), .OW(16), .SHIFT(0), .SIGNED(1)) u1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_last(in_last),
      .a_value(a_value), .b_value(b_value),
      .out_vld(ovld[1]), .s_out(sout[1]), .sat(osat[1]), .busy(obusy[1]));
   dsp_mac_acc #(.DW(16), .AW(40), .OW(16), .SHIFT(8), .SIGNED(1)) u2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_last(in_last),
      .a_value(a_value), .b_value(b_value),
      .out_vld(ovld[2]), .s_out(sout[2]), .sat(osat[2]), .busy(obusy[2]));
   dsp_mac_acc #(.DW(16), .AW(40), .OW(16), .SHIFT(0), .SIGNED(0)) u3 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_last(in_last),
      .a_value(a_value), .b_value(b_value),
      .out_vld(ovld[3]), .s_out(sout[3]), .sat(osat[3]), .busy(obusy[3]));

   function automatic int aw_of(input int i);
      return (i == 1) ? 32 : 40;
   endfunction
   function automatic int sh_of(input int i);
      return (i == 2) ? 8 : 0;
   endfunction
   function automatic bit sg_of(input int i);
      return (i != 3);
   endfunction

   function automatic void bounds(input int w, input bit sg,
                                  output logic signed [127:0] lo,
                                  output logic signed [127:0] hi);
      if (sg) begin
         hi = (128'sd1 <<< (w - 1)) - 128'sd1;
         lo = -(128'sd1 <<< (w - 1));
      end else begin
         hi = (128'sd1 <<< w) - 128'sd1;
         lo = 128'sd0;
      end
   endfunction

   function automatic logic signed [127:0] clamp128(input logic signed [127:0] v,
                                                    input logic signed [127:0] lo,
                                                    input logic signed [127:0] hi,
                                                    output logic hit);
      hit = 1'b1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      hit = 1'b0;
      return v;
   endfunction

   // Reference finaliser: round half-up, floor-shift, clamp to 16 bits.
   function automatic void fin_model(input int i, input logic signed [127:0] x,
                                     output logic [15:0] s, output logic ns);
      logic signed [127:0] v, lo, hi;
      logic h1, h2;
      v  = x;
      h1 = 1'b0;
      if (sh_of(i) > 0) begin
         bounds(aw_of(i), sg_of(i), lo, hi);
         v = clamp128(v + (128'sd1 <<< (sh_of(i) - 1)), lo, hi, h1);
         v = v >>> sh_of(i);
      end
      bounds(16, sg_of(i), lo, hi);
      v  = clamp128(v, lo, hi, h2);
      s  = v[15:0];
      ns = h1 | h2;
   endfunction

   task automatic model_flush();
      for (int i = 0; i < 4; i++) begin
         macc[i] = '0;
         mst[i]  = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   // Every cycle: out_vld must pulse exactly when the scoreboard head is due.
   task automatic check_cycle();
      exp_t e;
      logic hit;
      hit = (sb.size() > 0) && (sb[0].due == 32'(cyc));
      chk($sformatf("out_vld@%0d", cyc), 64'(ovld), hit ? 64'hF : 64'h0);
      if (hit) begin
         e = sb.pop_front();
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("s_out_u%0d@%0d", i, cyc), 64'(sout[i]), 64'(e.s[i]));
            chk($sformatf("sat_u%0d@%0d", i, cyc), 64'(osat[i]), 64'(e.sat[i]));
            last_s[i]   = e.s[i];
            last_sat[i] = e.sat[i];
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      check_cycle();
   endtask

   task automatic idle(input int n);
      in_vld  = 1'b0;
      in_last = 1'b0;
      a_value = '0;
      b_value = '0;
      repeat (n) step();
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic last);
      logic signed [127:0] p, t, lo, hi;
      logic        h, ns;
      logic [15:0] s;
      exp_t        e;
      in_vld  = 1'b1;
      in_last = last;
      a_value = a;
      b_value = b;
      e       = '0;
      e.due   = 32'(cyc + 3);
      for (int i = 0; i < 4; i++) begin
         if (sg_of(i)) p = 128'($signed(a)) * 128'($signed(b));
         else          p = $signed(128'(a) * 128'(b));
         bounds(aw_of(i), sg_of(i), lo, hi);
         t      = clamp128(macc[i] + p, lo, hi, h);
         mst[i] = mst[i] | h;
         if (last) begin
            fin_model(i, t, s, ns);
            e.s[i]   = s;
            e.sat[i] = mst[i] | ns;
            macc[i]  = '0;
            mst[i]   = 1'b0;
         end else begin
            macc[i] = t;
         end
      end
      if (last) sb.push_back(e);
      step();
   endtask

   initial begin
      rst_n   = 1'b0;
      clr     = 1'b0;
      in_vld  = 1'b0;
      in_last = 1'b0;
      a_value = '0;
      b_value = '0;
      model_flush();
      for (int i = 0; i < 4; i++) begin
         last_s[i]   = '0;
         last_sat[i] = 1'b0;
      end
      idle(3);
      chk("rst_out_vld", 64'(ovld), 64'h0);
      chk("rst_busy", 64'(obusy), 64'h0);
      chk("rst_sat", 64'(osat), 64'h0);
      for (int i = 0; i < 4; i++) chk($sformatf("rst_s_out_u%0d", i), 64'(sout[i]), 64'h0);
      rst_n = 1'b1;
      idle(2);

      // single product group, latency and busy fall
      drive(16'd3, 16'd4, 1'b1);
      idle(1);
      chk("t1_busy_inflight", 64'(obusy), 64'hF);
      idle(1);
      chk("t1_busy_after", 64'(obusy), 64'h0);
      idle(2);

      // back-to-back groups with no bubble between them
      repeat (3) drive(16'd100, 16'd100, 1'b0);
      drive(16'd100, 16'd100, 1'b1);
      drive(16'd2, 16'd3, 1'b1);
      idle(5);

      // accumulator clamp at the negative end
      repeat (2) drive(16'h8000, 16'h7FFF, 1'b0);
      drive(16'h8000, 16'h7FFF, 1'b1);
      idle(5);

      // rounding shift cases
      drive(16'd16, 16'd24, 1'b1);
      drive(16'hFFF0, 16'd24, 1'b1);
      drive(16'd1000, 16'd1000, 1'b1);
      idle(5);

      // bubbles inside a group, then clr discarding the open group
      drive(16'd5, 16'd5, 1'b0);
      idle(2);
      chk("t5_busy_open", 64'(obusy), 64'hF);
      clr     = 1'b1;
      in_vld  = 1'b1;
      in_last = 1'b0;
      a_value = 16'd7;
      b_value = 16'd7;
      model_flush();
      step();
      clr = 1'b0;
      chk("t5_busy_clr", 64'(obusy), 64'h0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t5_hold_s_u%0d", i), 64'(sout[i]), 64'(last_s[i]));
         chk($sformatf("t5_hold_sat_u%0d", i), 64'(osat[i]), 64'(last_sat[i]));
      end
      drive(16'd5, 16'd5, 1'b1);
      idle(5);

      // unsigned narrowing, then reset mid-group
      drive(16'hFFFF, 16'hFFFF, 1'b1);
      idle(5);
      drive(16'd1, 16'd1, 1'b0);
      drive(16'd2, 16'd2, 1'b1);
      rst_n   = 1'b0;
      in_vld  = 1'b0;
      in_last = 1'b0;
      sb.delete();
      model_flush();
      #1;
      chk("t6_rst_busy_now", 64'(obusy), 64'h0);
      idle(4);
      chk("t6_rst_busy", 64'(obusy), 64'h0);
      chk("t6_rst_sat", 64'(osat), 64'h0);
      for (int i = 0; i < 4; i++) chk($sformatf("t6_rst_s_out_u%0d", i), 64'(sout[i]), 64'h0);
      rst_n = 1'b1;
      idle(1);
      drive(16'd2, 16'd3, 1'b1);
      idle(5);
      chk("sb_drained", 64'(sb.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
